multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencer for the LEGv8 datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB and drives the same control lines the single-cycle decoder produces (Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp). It adds PC/IR write strobes, ready/valid handshakes to instruction and data memory, a memory-wait timeout and a sticky trap for illegal opcodes. It sits between the instruction register and the shared datapath/memory port.

## Interface
- WAIT_MAX, 15: maximum cycles a memory request may wait for ready before trapping (≥1).
- CNT_W, 32: width of the retired-instruction counter.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- opcode  in  11  IR[31:21]; valid from DECODE onward.
- zero  in  1  ALU zero flag; sampled in EXEC.
- imem_ready  in  1  instruction memory returns data this cycle.
- dmem_ready  in  1  data memory completes access this cycle.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  latch instruction into IR.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write  out  1 each  datapath controls.
- alu_op  out  2  {ALUOp1, ALUOp0}.
- trap  out  1  sticky error flag.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none.
- state  out  3  current state, for debug.
- instr_count  out  CNT_W  retired instructions (only with PERF_CNT_EN).

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Decode classes, with x as don't-care:
  - R = 1xx0101x000
  - LDUR = 11111000010
  - STUR = 11111000000
  - CBZ = 10110100xxx
  - Anything else is illegal.
- FETCH: imem_req=1.
  - On imem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: all strobes 0. Illegal opcode goes to TRAP with cause 01; any legal opcode goes to EXEC.
- EXEC, per class:
  - R: reg2loc=0, alu_src=0, alu_op=10; next WB.
  - LDUR/STUR: alu_src=1, alu_op=00; STUR also drives reg2loc=1; next MEM.
  - CBZ: reg2loc=1, alu_src=0, alu_op=01. If zero, pc_write=1 and pc_src=1. Next FETCH; the instruction retires here.
- MEM: datapath selects held from EXEC.
  - LDUR: mem_read=1. On dmem_ready go to WB.
  - STUR: mem_write=1. On dmem_ready go to FETCH; the instruction retires here.
- WB: reg_write=1, then FETCH; the instruction retires here.
  - R: mem_to_reg=0.
  - LDUR: mem_to_reg=1, alu_src=1.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle ready is low in those states.
  - If the counter reaches WAIT_MAX with ready still low, go to TRAP with cause 10.
  - Ready arriving in the same cycle the counter hits WAIT_MAX counts as success.
- TRAP:
  - All strobes and controls are 0; trap=1.
  - trap_cause holds its value; the block stays in TRAP until rst.
- Control outputs are combinational from state, registered class and handshake inputs.
- Strobes (ir_write, pc_write, reg_write, mem_read, mem_write) are never asserted outside the states listed above.

## Timing
- Reset:
  - state=FETCH; trap=0; trap_cause=00; wait counter=0; class=R; instr_count=0.
  - During rst=1 every output is 0 and state reads 0.
- rst asserted mid-instruction aborts it on the next edge. No pending write completes; it is not counted as retired.
- The opcode class is registered at the end of DECODE. Opcode changes after DECODE are ignored.
- Latency, with ready high on first request:
  - R = 4 cycles
  - LDUR = 5 cycles
  - STUR = 4 cycles
  - CBZ = 3 cycles
  - Each wait cycle adds 1.
- imem_ready/dmem_ready are ignored outside FETCH/MEM.

## Configuration
- PERF_CNT_EN defined:
  - instr_count increments by 1 on every retiring edge (CBZ EXEC exit, STUR MEM exit, WB exit).
  - It wraps modulo 2^CNT_W and is frozen in TRAP.
- PERF_CNT_EN undefined:
  - The instr_count port is absent and the counter logic is not synthesized.
  - All other behaviour is identical.

## Test plan
- ADD, opcode 10001011000, ready tied high:
  - States 0→1→2→4→0.
  - EXEC alu_op=10; WB reg_write=1, mem_to_reg=0.
  - instr_count=1 after 4 cycles.
- LDUR with dmem_ready delayed 3 cycles:
  - mem_read held 4 cycles in MEM, then WB with reg_write=1, mem_to_reg=1.
  - Total 8 cycles.
- CBZ, opcode 10110100101:
  - zero=1: pc_write=1, pc_src=1 in EXEC, back to FETCH in 3 cycles.
  - zero=0: pc_write=0 in EXEC.
- Illegal opcode 00000000000: DECODE→TRAP; trap=1, trap_cause=01; stays until rst; then state=0, trap=0.
- Timeouts, WAIT_MAX=15, STUR with dmem_ready low:
  - Ready held low: TRAP with cause 10 after 15 wait cycles.
  - Ready rising exactly at count 15: completes, no trap.
- rst asserted in MEM of a STUR: next cycle state=0, mem_write=0, instr_count unchanged.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle LEGv8 control sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath control lines, PC/IR strobes and memory handshakes. A per-request
// wait counter traps on memory timeout; illegal opcodes trap in DECODE.
// Optional feature macro: PERF_CNT_EN adds the retired-instruction counter
// and the instr_count_o port.
module multicycle_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [10:0]       opcode_i,
  input  logic              zero_i,
  input  logic              imem_ready_i,
  input  logic              dmem_ready_i,
  output logic              imem_req_o,
  output logic              ir_write_o,
  output logic              pc_write_o,
  output logic              pc_src_o,
  output logic              reg2loc_o,
  output logic              alu_src_o,
  output logic              mem_to_reg_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [1:0]        alu_op_o,
  output logic              trap_o,
  output logic [1:0]        trap_cause_o,
  output logic [2:0]        state_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  instr_count_o
`endif
);

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    C_R    = 2'd0,
    C_LDUR = 2'd1,
    C_STUR = 2'd2,
    C_CBZ  = 2'd3
  } cls_e;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  logic [1:0]          cause_q, cause_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

  cls_e                dec_cls;
  logic                dec_legal;
  logic                wait_expired;

  // Opcode classification; only consumed in DECODE.
  always_comb begin
    dec_cls   = C_R;
    dec_legal = 1'b1;
    casez (opcode_i)
      11'b1??0101?000: dec_cls = C_R;
      11'b11111000010: dec_cls = C_LDUR;
      11'b11111000000: dec_cls = C_STUR;
      11'b10110100???: dec_cls = C_CBZ;
      default:         dec_legal = 1'b0;
    endcase
  end

  assign wait_expired = (wcnt_q == WCNT_W'(WAIT_MAX));

  // Next-state and control outputs; everything forced low while in reset.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    cause_d      = cause_q;
    wcnt_d       = wcnt_q;
    imem_req_o   = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    reg2loc_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    alu_op_o     = 2'b00;
    trap_o       = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          imem_req_o = 1'b1;
          if (imem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            state_d    = S_DECODE;
          end else if (wait_expired) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
        S_DECODE: begin
          if (dec_legal) begin
            cls_d   = dec_cls;
            state_d = S_EXEC;
          end else begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_R: begin
              alu_op_o = 2'b10;
              state_d  = S_WB;
            end
            C_LDUR, C_STUR: begin
              alu_src_o = 1'b1;
              reg2loc_o = (cls_q == C_STUR);
              wcnt_d    = '0;
              state_d   = S_MEM;
            end
            default: begin
              reg2loc_o  = 1'b1;
              alu_op_o   = 2'b01;
              pc_write_o = zero_i;
              pc_src_o   = zero_i;
              wcnt_d     = '0;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          // Address selects stay as they were in EXEC for the whole access.
          alu_src_o   = 1'b1;
          reg2loc_o   = (cls_q == C_STUR);
          mem_read_o  = (cls_q == C_LDUR);
          mem_write_o = (cls_q != C_LDUR);
          if (dmem_ready_i) begin
            wcnt_d  = '0;
            state_d = (cls_q == C_LDUR) ? S_WB : S_FETCH;
          end else if (wait_expired) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
        S_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = (cls_q == C_LDUR);
          alu_src_o    = (cls_q == C_LDUR);
          wcnt_d       = '0;
          state_d      = S_FETCH;
        end
        S_TRAP: begin
          trap_o = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
          wcnt_d  = '0;
        end
      endcase
    end
  end

  assign state_o      = rst_i ? 3'd0 : state_q;
  assign trap_cause_o = rst_i ? 2'b00 : cause_q;

  // Sequencer state, latched class, trap cause and wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
      cause_q <= 2'b00;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  assign retire = ((state_q == S_EXEC) && (cls_q == C_CBZ)) ||
                  ((state_q == S_MEM) && (cls_q == C_STUR) && dmem_ready_i) ||
                  (state_q == S_WB);

  // Retired-instruction counter; cannot move in TRAP since nothing retires there.
  always_ff @(posedge clk_i) begin
    if (rst_i)       cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instr_count_o = rst_i ? '0 : cnt_q;
`endif

endmodule
